fetch_prefetch_unit: RTL and testbench
======================================

# fetch_prefetch_unit

Parametrised instruction-fetch stage with a DEPTH-entry prefetch queue between instruction memory and the IF/ID register. It generates word-addressed PCs, issues one read per cycle to a synchronous 1-cycle-latency instruction memory, and buffers the returned {pc, instruction} pairs. It presents them to decode through a valid/ready handshake. It also supports branch/jump redirect with queue flush, debug stop/single-step, and a program-load mode that hands the memory port to the loader.

## Interface
- ADDR_W, 32: PC / memory address width (word address).
- DATA_W, 32: instruction width.
- DEPTH, 4: prefetch queue entries; power of two, ≥2.
- RESET_PC, 0: first fetch address after reset and after load mode.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- redirect  in  1  taken branch/jump this cycle.
- redirect_pc  in  ADDR_W  target address.
- out_ready  in  1  IF/ID accepts (stall = 0).
- out_valid  out  1  queue head valid.
- out_pc  out  ADDR_W  address of head instruction.
- out_next_pc  out  ADDR_W  out_pc + 1.
- out_instr  out  DATA_W  head instruction.
- imem_rd  out  1  read strobe.
- imem_we  out  1  write strobe (load mode only).
- imem_addr  out  ADDR_W  memory address.
- imem_wdata  out  DATA_W  write data.
- imem_rdata  in  DATA_W  read data, valid the cycle after imem_rd.
- load_mode  in  1  program-load mode.
- load_addr  in  ADDR_W  loader address.
- load_data  in  DATA_W  loader data.
- load_we  in  1  loader write strobe.
- dbg_stop  in  1  halt issuing new fetches.
- dbg_step  in  1  one-cycle pulse: issue exactly one fetch while stopped.
- dbg_pc  out  ADDR_W  next address to fetch (fetch_pc).

## Operation
- State: fetch_pc, queue (DEPTH × {pc, instr}, rd/wr pointers, count 0..DEPTH), inflight flag + inflight_pc, kill flag, step_pending.
- Priority per cycle: rst > load_mode > redirect > normal push/pop.
- pop = out_valid & out_ready. credit = (count + inflight − pop) < DEPTH.
- issue = !load_mode & !redirect & credit & (!dbg_stop | step_pending | dbg_step).
- On issue: imem_rd=1, imem_addr=fetch_pc. Then inflight←1, inflight_pc←fetch_pc, fetch_pc←fetch_pc+1 (wraps 2^ADDR_W−1 → 0). Otherwise inflight←0.
- Response: if inflight & !kill, push {inflight_pc, imem_rdata} at the tail. Push and pop may occur in the same cycle; count is unchanged.
- Credit guarantees count never exceeds DEPTH. A push to a full queue cannot occur; if one does, it is an assertion failure.
- Redirect: queue cleared (count←0, pointers←0); fetch_pc←redirect_pc; no issue this cycle; kill←inflight so next-cycle data is dropped; step_pending cleared. A pop in the same cycle is lost and the head is discarded.
- load_mode: imem_addr=load_addr, imem_we=load_we, imem_wdata=load_data, imem_rd=0. Queue is cleared, in-flight data is dropped, fetch_pc is held at RESET_PC, redirect is ignored, and out_valid=0. Fetch resumes from RESET_PC the cycle after load_mode falls.
- Debug: dbg_stop blocks issue only; pops and in-flight captures continue. A dbg_step with no credit sets step_pending, and the step is issued at the first credit cycle. dbg_step with dbg_stop=0 has no effect.
- Outputs out_* are registered queue-head fields; out_next_pc = out_pc + 1 (ADDR_W wrap).

## Timing
- Reset values: fetch_pc=RESET_PC, count=0, inflight=0, kill=0, step_pending=0, out_valid=0, out_pc=0, out_instr=0, imem_rd=0, imem_we=0, dbg_pc=RESET_PC. imem_rd is forced 0 while rst is high.
- Fetch latency: issue in cycle N, data captured at end of N+1, out_valid in cycle N+2.
- After rst deasserts, the first issue is in cycle 0 (RESET_PC) and out_valid=1 in cycle 2.
- Redirect in cycle R: first issue of redirect_pc in R+1, out_valid in R+3.
- Throughput with out_ready=1 and dbg_stop=0 is 1 instruction/cycle for any DEPTH ≥ 2.
- With out_ready=0, the unit issues until count + inflight = DEPTH, then imem_rd=0.
- Asynchronous rst mid-operation clears the queue immediately; the response to any outstanding read is ignored.

## Test plan
- Reset release, imem[i]=0x1000+i, out_ready=1 → out_valid from cycle 2; out_pc 0,1,2,… every cycle; out_instr 0x1000+pc; out_next_pc = pc+1.
- Hold out_ready=0, DEPTH=4 → exactly 4 reads issued, count=4, imem_rd=0; release → heads pc 0..3 popped, then resume at pc 4 with no gap or duplicate.
- Redirect to 0x40 while queue holds pc 5..7 and pc 8 is in flight → pc 5..8 never appear; next out_pc=0x40 exactly 3 cycles after redirect.
- dbg_stop=1 with queue drained, pulse dbg_step twice → exactly two reads (consecutive pcs), two outputs, dbg_pc advanced by 2.
- load_mode=1 with writes to addr 0..3 = 0xA..0xD → imem_we follows load_we, no reads, out_valid=0; drop load_mode → out_pc 0..3 with instr 0xA..0xD.
- fetch_pc = 2^ADDR_W−1 → next out_pc=0; assert rst mid-stream → out_valid=0 immediately and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage: issues one word read per cycle and buffers {pc, instr}
// pairs in a DEPTH-entry queue ahead of decode, with redirect, debug step and load mode.
module fetch_prefetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_next_pc,
  output logic [DATA_W-1:0] out_instr,
  output logic              imem_rd,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              load_mode,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_we,
  input  logic              dbg_stop,
  input  logic              dbg_step,
  output logic [ADDR_W-1:0] dbg_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = PW + 2;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic [ADDR_W-1:0] q_pc    [DEPTH];
  logic [DATA_W-1:0] q_instr [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic              inflight;
  logic              kill;
  logic              step_pending;

  logic              flush;
  logic              pop;
  logic              push;
  logic              credit;
  logic              issue;
  logic              step_next;
  logic [LW-1:0]     level;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    flush     = load_mode | redirect;
    out_valid = (count != '0) & ~load_mode;
    pop       = out_valid & out_ready;
    push      = inflight & ~kill & ~flush;
    // Occupancy the queue will have once the outstanding read lands.
    level     = LW'(count) + LW'(inflight) - LW'(pop);
    credit    = level < LW'(DEPTH);
    issue     = ~rst & ~load_mode & ~redirect & credit &
                (~dbg_stop | step_pending | dbg_step);

    step_next = step_pending;
    if (flush || !dbg_stop) step_next = 1'b0;
    else if (issue)         step_next = 1'b0;
    else if (dbg_step)      step_next = 1'b1;
  end

  assign imem_rd     = issue;
  assign imem_we     = ~rst & load_mode & load_we;
  assign imem_addr   = load_mode ? load_addr : fetch_pc;
  assign imem_wdata  = load_data;
  assign out_pc      = q_pc[rd_ptr];
  assign out_instr   = q_instr[rd_ptr];
  assign out_next_pc = out_pc + ADDR_W'(1);
  assign dbg_pc      = fetch_pc;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc     <= RESET_PC;
      inflight     <= 1'b0;
      inflight_pc  <= '0;
      kill         <= 1'b0;
      step_pending <= 1'b0;
    end else begin
      inflight     <= issue;
      step_pending <= step_next;
      // A read outstanding at redirect belongs to the abandoned path.
      kill         <= redirect & ~load_mode & inflight;
      if (issue) inflight_pc <= fetch_pc;
      if (load_mode)     fetch_pc <= RESET_PC;
      else if (redirect) fetch_pc <= redirect_pc;
      else if (issue)    fetch_pc <= fetch_pc + ADDR_W'(1);
    end
  end

  // NOTE: the queue storage is reset so the head fields read zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q_pc[wr_ptr]    <= inflight_pc;
        q_instr[wr_ptr] <= imem_rdata;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && count == CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Scoreboard bench: the expected stream is the program-order PC sequence since the
// last reset/redirect/load; a monitor compares every accepted output against it.
module tb_fetch_prefetch_unit;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          out_ready;
  logic          out_valid;
  logic [AW-1:0] out_pc;
  logic [AW-1:0] out_next_pc;
  logic [DW-1:0] out_instr;
  logic          imem_rd;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;
  logic [DW-1:0] imem_rdata;
  logic          load_mode;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          load_we;
  logic          dbg_stop;
  logic          dbg_step;
  logic [AW-1:0] dbg_pc;

  int checks    = 0;
  int failures  = 0;
  int rd_count  = 0;
  int pop_count = 0;

  always #5 clk = ~clk;

  fetch_prefetch_unit #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .DEPTH   (DEPTH),
    .RESET_PC('0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_next_pc(out_next_pc),
    .out_instr  (out_instr),
    .imem_rd    (imem_rd),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .imem_rdata (imem_rdata),
    .load_mode  (load_mode),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_we    (load_we),
    .dbg_stop   (dbg_stop),
    .dbg_step   (dbg_step),
    .dbg_pc     (dbg_pc)
  );

  // Instruction memory: default word 0x1000+addr, low 16 words writable.
  logic [DW-1:0] wmem   [16];
  logic          wvalid [16] = '{default: 1'b0};

  always @(posedge clk) begin
    if (imem_we && imem_addr < 16) begin
      wmem[imem_addr[3:0]]   <= imem_wdata;
      wvalid[imem_addr[3:0]] <= 1'b1;
    end
    if (imem_rd) begin
      if (imem_addr < 16 && wvalid[imem_addr[3:0]]) imem_rdata <= wmem[imem_addr[3:0]];
      else                                          imem_rdata <= DW'(32'h1000 + imem_addr);
    end
  end

  // Reference program image, maintained independently from the loader stimulus.
  logic [DW-1:0] mdl_mem   [16];
  logic          mdl_valid [16] = '{default: 1'b0};
  exp_t          exp_q [$];
  logic [AW-1:0] model_pc;

  function automatic logic [DW-1:0] exp_instr(input logic [AW-1:0] pc);
    if (pc < 16 && mdl_valid[pc[3:0]]) return mdl_mem[pc[3:0]];
    return DW'(32'h1000 + pc);
  endfunction

  function automatic void refill();
    exp_t e;
    while (exp_q.size() < 16) begin
      e.pc    = model_pc;
      e.instr = exp_instr(model_pc);
      exp_q.push_back(e);
      model_pc = model_pc + AW'(1);
    end
  endfunction

  function automatic void restart(input logic [AW-1:0] pc);
    exp_q.delete();
    model_pc = pc;
    refill();
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!load_mode) refill();
  endtask

  task automatic set_redirect(input logic [AW-1:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    restart(pc);
  endtask

  // Monitor: every accepted head must be the next expected program-order entry.
  always @(negedge clk) begin
    exp_t          e;
    logic [AW-1:0] npc;
    if (!rst && imem_rd) rd_count++;
    if (!rst && out_valid && out_ready && !redirect && !load_mode) begin
      pop_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_output actual_pc=0x%0h expected=none", out_pc);
      end else begin
        e   = exp_q.pop_front();
        npc = e.pc + AW'(1);
        check("sb_pc", out_pc, e.pc);
        check("sb_instr", out_instr, e.instr);
        check("sb_next_pc", out_next_pc, npc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            r;
    int            p;
    int            p0;
    logic [AW-1:0] d;
    logic [AW-1:0] dexp;
    logic [AW-1:0] target;

    redirect    = 1'b0;
    redirect_pc = '0;
    out_ready   = 1'b1;
    load_mode   = 1'b0;
    load_addr   = '0;
    load_data   = '0;
    load_we     = 1'b0;
    dbg_stop    = 1'b0;
    dbg_step    = 1'b0;
    model_pc    = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_imem_rd", imem_rd, 0);
    check("rst_imem_we", imem_we, 0);
    check("rst_dbg_pc", dbg_pc, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_instr", out_instr, 0);

    // Release: issue in cycle 0, head valid in cycle 2.
    rst = 1'b0;
    restart('0);
    @(negedge clk);
    check("c0_imem_rd", imem_rd, 1);
    check("c0_imem_addr", imem_addr, 0);
    check("c0_out_valid", out_valid, 0);
    tick();
    @(negedge clk);
    check("c1_out_valid", out_valid, 0);
    tick();
    @(negedge clk);
    check("c2_out_valid", out_valid, 1);
    check("c2_out_pc", out_pc, 0);
    repeat (10) tick();
    p = pop_count;
    repeat (10) tick();
    check("throughput_pops", pop_count - p, 10);

    // Stall fill: exactly DEPTH reads from an empty queue.
    out_ready = 1'b0;
    r = rd_count;
    set_redirect(AW'(32'h100));
    tick();
    redirect = 1'b0;
    repeat (9) tick();
    @(negedge clk);
    check("stall_reads", rd_count - r, DEPTH);
    check("stall_imem_rd_low", imem_rd, 0);
    check("stall_out_valid", out_valid, 1);
    check("stall_head_pc", out_pc, 32'h100);
    tick();
    out_ready = 1'b1;
    p = pop_count;
    repeat (12) tick();
    check("stall_release_pops", pop_count - p, 12);

    // Redirect with three queued entries and one read in flight.
    out_ready = 1'b0;
    repeat (6) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    set_redirect(AW'(32'h40));
    tick();
    redirect  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("redir_r1_valid", out_valid, 0);
    tick();
    @(negedge clk);
    check("redir_r2_valid", out_valid, 0);
    tick();
    @(negedge clk);
    check("redir_r3_valid", out_valid, 1);
    check("redir_r3_pc", out_pc, 32'h40);
    repeat (5) tick();

    // Debug stop then two single steps.
    dbg_stop = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    check("dbg_drained_valid", out_valid, 0);
    check("dbg_stopped_rd", imem_rd, 0);
    tick();
    r    = rd_count;
    p    = pop_count;
    d    = dbg_pc;
    dexp = d + AW'(2);
    dbg_step = 1'b1;
    tick();
    dbg_step = 1'b0;
    repeat (3) tick();
    dbg_step = 1'b1;
    tick();
    dbg_step = 1'b0;
    repeat (6) tick();
    check("dbg_step_reads", rd_count - r, 2);
    check("dbg_step_pops", pop_count - p, 2);
    check("dbg_pc_advance", dbg_pc, dexp);

    // Step without credit is held until a slot frees.
    dbg_stop  = 1'b0;
    out_ready = 1'b0;
    repeat (8) tick();
    dbg_stop = 1'b1;
    r = rd_count;
    dbg_step = 1'b1;
    @(negedge clk);
    check("step_nocredit_rd", imem_rd, 0);
    tick();
    dbg_step = 1'b0;
    repeat (3) tick();
    check("step_pending_hold", rd_count - r, 0);
    out_ready = 1'b1;
    @(negedge clk);
    check("step_pending_issue", imem_rd, 1);
    tick();
    out_ready = 1'b0;
    repeat (4) tick();
    check("step_single_read", rd_count - r, 1);
    dbg_stop  = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();

    // Program load: writes go straight to memory; redirect ignored.
    load_mode = 1'b1;
    exp_q.delete();
    redirect    = 1'b1;
    redirect_pc = AW'(32'h77);
    for (int i = 0; i < 4; i++) begin
      load_addr = AW'(i);
      load_data = DW'(32'hA + i);
      load_we   = 1'b1;
      mdl_mem[i]   = DW'(32'hA + i);
      mdl_valid[i] = 1'b1;
      @(negedge clk);
      check("load_imem_we", imem_we, 1);
      check("load_imem_rd", imem_rd, 0);
      check("load_out_valid", out_valid, 0);
      check("load_imem_addr", imem_addr, i);
      check("load_imem_wdata", imem_wdata, 32'hA + i);
      tick();
      redirect = 1'b0;
    end
    load_we = 1'b0;
    @(negedge clk);
    check("load_we_low", imem_we, 0);
    check("load_dbg_pc", dbg_pc, 0);
    tick();
    load_mode = 1'b0;
    restart('0);
    @(negedge clk);
    check("load_resume_rd", imem_rd, 1);
    check("load_resume_addr", imem_addr, 0);
    repeat (10) tick();

    // Address wrap.
    set_redirect(AW'(32'hFFFF_FFFE));
    tick();
    redirect = 1'b0;
    repeat (10) tick();

    // Asynchronous reset mid-stream.
    @(posedge clk);
    #3;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_imem_rd", imem_rd, 0);
    check("arst_dbg_pc", dbg_pc, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    restart('0);
    @(negedge clk);
    check("arst_restart_rd", imem_rd, 1);
    check("arst_restart_addr", imem_addr, 0);
    repeat (6) tick();

    // Randomised traffic against the program-order model.
    p0 = pop_count;
    for (int c = 0; c < 2000; c++) begin
      tick();
      redirect  = 1'b0;
      dbg_step  = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) < 3) begin
        if ($urandom_range(0, 1) != 0) target = AW'($urandom);
        else                           target = AW'(32'hFFFF_FFFC) + AW'($urandom_range(0, 3));
        set_redirect(target);
      end
      if ($urandom_range(0, 49) == 0) dbg_stop = ~dbg_stop;
      if (dbg_stop && $urandom_range(0, 3) == 0) dbg_step = 1'b1;
    end
    tick();
    redirect  = 1'b0;
    dbg_step  = 1'b0;
    dbg_stop  = 1'b0;
    out_ready = 1'b1;
    check("rand_progress", (pop_count - p0) > 200, 1);
    repeat (6) tick();
    @(negedge clk);
    check("final_stream_valid", out_valid, 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
